// File: rtl/param_bram_arbiter_pkg.sv
// Shared constants for the parameter-BRAM subsystem: arbiter FSM encoding,
// BRAM region map and default read latency.
package nn_params_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam int unsigned DEFAULT_RD_LAT     = 2;
  localparam int unsigned LAYER1_WEIGHT_BASE = 0;
  localparam int unsigned LAYER1_BIAS_BASE   = 147576;
  localparam int unsigned LAYER2_WEIGHT_BASE = 147704;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/param_bram_arbiter_if.sv
// Loader-side bus of the parameter BRAM arbiter: burst requests in,
// grant / tagged read data / done out.
interface param_bram_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 16
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*ADDR_WIDTH-1:0] base_addr;
    logic [N_REQ*LEN_WIDTH-1:0]  len;
    logic [N_REQ-1:0]            grant;
    logic                        rd_valid;
    logic [W-1:0]                rd_data;
    logic [LEN_WIDTH-1:0]        rd_idx;
    logic [N_REQ-1:0]            done;

    modport master (
        output req, base_addr, len,
        input  grant, rd_valid, rd_data, rd_idx, done
    );

    modport slave (
        input  req, base_addr, len,
        output grant, rd_valid, rd_data, rd_idx, done
    );
endinterface

// File: rtl/param_bram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around; returns one-hot grant plus its index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any_gnt
);
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            int cand;
            cand = (int'(ptr) + off) % N_REQ;
            if (!any_gnt && req[cand]) begin
                any_gnt   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = PTR_W'(cand);
            end
        end
    end
endmodule

// File: rtl/param_bram_arbiter.sv
// Shares one read-only parameter BRAM port among N_REQ burst loaders,
// round-robin, one read per cycle, data returned tagged with its index.
module param_bram_arbiter
    import nn_params_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 16,
    parameter int RD_LAT     = DEFAULT_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    param_bram_arbiter_if.slave   bus,
    output logic                  busy,
    output logic                  bram_en,
    output logic                  bram_ren,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [W-1:0]          bram_dout
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, owner_q, arb_idx;
    logic [N_REQ-1:0]     arb_gnt, grant_q, done_q;
    logic                 arb_any;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [LEN_WIDTH-1:0] sel_len, len_q, issue_idx, push_idx;
    logic                 last_issue, pipe_empty;
    logic                 load, issue_more, issue_stop, fire_done, rel_owner, push;
    logic [RD_LAT-1:0]    pipe_v;
    logic [LEN_WIDTH-1:0] pipe_idx [RD_LAT];
    logic                 rd_valid_q;
    logic [W-1:0]         rd_data_q;
    logic [LEN_WIDTH-1:0] rd_idx_q;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_gnt (arb_any)
    );

    assign sel_base   = bus.base_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len    = bus.len[int'(arb_idx)*LEN_WIDTH +: LEN_WIDTH];
    assign last_issue = (issue_idx == len_q - LEN_WIDTH'(1));
    assign pipe_empty = ~|pipe_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            state_q <= state_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

    // A zero-length burst skips ISSUE so done lands one cycle after grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (arb_any) state_d = (sel_len == '0) ? ST_DRAIN : ST_ISSUE;
            ST_ISSUE:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN:   if (pipe_empty) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load       = (state_q == ST_IDLE) && arb_any;
        issue_more = (state_q == ST_ISSUE) && !last_issue;
        issue_stop = (state_q == ST_ISSUE) && last_issue;
        fire_done  = (state_q == ST_DRAIN) && pipe_empty;
        rel_owner  = (state_q == ST_RELEASE);
        push       = (load && sel_len != '0) || issue_more;
        push_idx   = load ? '0 : issue_idx + LEN_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= '0;
            done_q     <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            len_q      <= '0;
            issue_idx  <= '0;
            bram_en    <= 1'b0;
            bram_ren   <= 1'b0;
            bram_addr  <= '0;
            pipe_v     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_idx_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_idx[i] <= '0;
        end else begin
            done_q <= '0;
            if (load) begin
                grant_q <= arb_gnt;
                owner_q <= arb_idx;
                len_q   <= sel_len;
                if (sel_len != '0) begin
                    bram_en   <= 1'b1;
                    bram_ren  <= 1'b1;
                    bram_addr <= sel_base;
                    issue_idx <= '0;
                end
            end
            if (issue_more) begin
                bram_addr <= bram_addr + ADDR_WIDTH'(1);
                issue_idx <= issue_idx + LEN_WIDTH'(1);
            end
            if (issue_stop) bram_ren <= 1'b0;
            if (fire_done) begin
                done_q  <= grant_q;
                bram_en <= 1'b0;
            end
            if (rel_owner) begin
                grant_q <= '0;
                ptr_q   <= PTR_W'(wrap_inc(int'(owner_q), N_REQ));
            end
            // The tag pipeline runs in step with the BRAM read latency.
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            pipe_v[0]   <= push;
            pipe_idx[0] <= push_idx;
            rd_valid_q  <= pipe_v[RD_LAT-1];
            if (pipe_v[RD_LAT-1]) begin
                rd_data_q <= bram_dout;
                rd_idx_q  <= pipe_idx[RD_LAT-1];
            end
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_idx   = rd_idx_q;
endmodule

// File: tb/tb_param_bram_arbiter.sv
// Directed bench for param_bram_arbiter: cycle-exact burst checks against
// a behavioural one-cycle BRAM whose word at address a is (a - 147575) mod 256.
module tb_param_bram_arbiter;
  localparam int N_REQ  = 4;
  localparam int W      = 8;
  localparam int AW     = 18;
  localparam int LW     = 16;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy, bram_en, bram_ren;
  logic [AW-1:0] bram_addr;
  logic [W-1:0]  bram_dout = '0;
  int            checks = 0;
  int            errors = 0;

  param_bram_arbiter_if #(.N_REQ(N_REQ), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  param_bram_arbiter #(
    .N_REQ(N_REQ), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .bram_en   (bram_en),
    .bram_ren  (bram_ren),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_word(input logic [AW-1:0] a);
    logic [AW-1:0] d;
    d = a - 18'd147575;
    return d[7:0];
  endfunction

  always @(posedge clk) if (bram_en && bram_ren) bram_dout <= model_word(bram_addr);

  task automatic set_req(input int i, input logic [AW-1:0] base, input int n);
    bus.base_addr[i*AW +: AW] = base;
    bus.len[i*LW +: LW]       = LW'(n);
    bus.req[i]                = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.grant !== '0 || bus.done !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0 ||
        bus.rd_idx !== '0 || busy !== 1'b0 || bram_en !== 1'b0 || bram_ren !== 1'b0 ||
        bram_addr !== '0) begin
      errors++;
      $display("FAIL %s outputs got gnt=%b done=%b v=%b d=%h idx=%0d busy=%b en=%b ren=%b addr=%0d exp all 0",
               tag, bus.grant, bus.done, bus.rd_valid, bus.rd_data, bus.rd_idx, busy,
               bram_en, bram_ren, bram_addr);
    end
  endtask

  // Called at the negedge of burst cycle 0 (IDLE sees req). drop_c: 0 = drop
  // req at done, -1 = keep holding, otherwise drop at that cycle.
  task automatic run_burst(input int owner, input logic [AW-1:0] base, input int n,
                           input int drop_c, input string tag);
    int d, drop_at;
    logic [N_REQ-1:0] oh, eg, ed;
    logic ev, er, een, eb;
    logic [AW-1:0] ea;
    logic [7:0] edat;
    logic [LW-1:0] eidx;
    d       = (n == 0) ? 2 : n + RD_LAT + 1;
    drop_at = (drop_c == 0) ? d : drop_c;
    oh      = N_REQ'(1 << owner);
    for (int c = 1; c <= d + 1; c++) begin
      @(negedge clk);
      eg   = (c <= d) ? oh : '0;
      ed   = (c == d) ? oh : '0;
      eb   = (c <= d);
      er   = (n > 0 && c <= n);
      een  = (n > 0 && c < d);
      ev   = (n > 0 && c >= RD_LAT + 1 && c <= n + RD_LAT);
      ea   = base + AW'(c - 1);
      edat = model_word(base + AW'(c - RD_LAT - 1));
      eidx = LW'(c - RD_LAT - 1);
      checks++;
      if (bus.grant !== eg) begin errors++; $display("FAIL %s grant cyc %0d got %b exp %b", tag, c, bus.grant, eg); end
      checks++;
      if (bus.done !== ed) begin errors++; $display("FAIL %s done cyc %0d got %b exp %b", tag, c, bus.done, ed); end
      checks++;
      if (busy !== eb) begin errors++; $display("FAIL %s busy cyc %0d got %b exp %b", tag, c, busy, eb); end
      checks++;
      if (bram_ren !== er) begin errors++; $display("FAIL %s bram_ren cyc %0d got %b exp %b", tag, c, bram_ren, er); end
      checks++;
      if (bram_en !== een) begin errors++; $display("FAIL %s bram_en cyc %0d got %b exp %b", tag, c, bram_en, een); end
      checks++;
      if (bus.rd_valid !== ev) begin errors++; $display("FAIL %s rd_valid cyc %0d got %b exp %b", tag, c, bus.rd_valid, ev); end
      if (er) begin
        checks++;
        if (bram_addr !== ea) begin errors++; $display("FAIL %s bram_addr cyc %0d got %0d exp %0d", tag, c, bram_addr, ea); end
      end
      if (ev) begin
        checks++;
        if (bus.rd_data !== edat) begin errors++; $display("FAIL %s rd_data cyc %0d got %h exp %h", tag, c, bus.rd_data, edat); end
        checks++;
        if (bus.rd_idx !== eidx) begin errors++; $display("FAIL %s rd_idx cyc %0d got %0d exp %0d", tag, c, bus.rd_idx, eidx); end
      end
      if (c == drop_at) bus.req[owner] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.base_addr = '0; bus.len = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  // All four held: order must be 0,1,2,3,0 with back-to-back bursts.
  task automatic test_contention();
    set_req(0, 18'd1000, 2);
    set_req(1, 18'd2000, 3);
    set_req(2, 18'd3000, 1);
    set_req(3, 18'd4000, 4);
    run_burst(0, 18'd1000, 2, -1, "cont_r0");
    run_burst(1, 18'd2000, 3, -1, "cont_r1");
    run_burst(2, 18'd3000, 1, -1, "cont_r2");
    run_burst(3, 18'd4000, 4, -1, "cont_r3");
    run_burst(0, 18'd1000, 2, -1, "cont_r0b");
    bus.req = '0;
  endtask

  task automatic test_single();
    set_req(0, 18'd147576, 8);
    run_burst(0, 18'd147576, 8, 0, "single");
    checks++;
    if (bus.rd_data !== 8'd8) begin errors++; $display("FAIL single rd_data_hold got %h exp %h", bus.rd_data, 8'd8); end
  endtask

  task automatic test_zero_len();
    set_req(2, 18'd5000, 0);
    run_burst(2, 18'd5000, 0, 0, "zero_len");
  endtask

  task automatic test_wrap();
    set_req(3, 18'd262142, 4);
    run_burst(3, 18'd262142, 4, 0, "wrap");
  endtask

  task automatic test_drop_mid_burst();
    set_req(1, 18'd500, 6);
    run_burst(1, 18'd500, 6, 5, "drop");
  endtask

  // Pointer is 2 before reset; with req=1001 a stale pointer would pick 3.
  task automatic test_reset_mid_burst();
    set_req(1, 18'd100, 8);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.grant !== 4'b0010) begin errors++; $display("FAIL rst_mid pre_grant got %b exp %b", bus.grant, 4'b0010); end
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_async");
    bus.req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.grant !== 4'b0001) begin errors++; $display("FAIL rst_mid first_grant got %b exp %b", bus.grant, 4'b0001); end
    bus.req = '0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_zero_len();
    test_wrap();
    test_drop_mid_burst();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
